fifo_rd_scheduler: RTL and testbench

FIFO_RD_SCHEDULER -- requirements
Module: fifo_rd_scheduler

---
 rtl/fifo_rd_scheduler_pkg.sv | 32 +++
 rtl/fifo_rd_scheduler_rr_arbiter.sv | 35 +++
 rtl/fifo_rd_scheduler.sv | 102 ++++++++++
 tb/tb_fifo_rd_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_scheduler_pkg
// Brief   : Shared FSM encoding, default parameters and helpers for the
//           FIFO read scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_rd_scheduler_pkg;

  localparam int DEF_N_REQ      = 4;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_SETTLE  = 2'd3
  } state_t;

  // Requester count never exceeds 8, so a fixed 8-bit one-hot covers all builds.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; search begins at i_ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fifo_rd_scheduler_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = $clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % N_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_scheduler
// Brief   : Shares one FIFO read port among N_REQ requesters, one word per
//           four-cycle IDLE/ASSERT/RELEASE/SETTLE transaction.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_rd_scheduler
  import fifo_rd_scheduler_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      i_req,
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_rd_line,
  output logic [N_REQ-1:0]      o_gnt,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_WIDTH-1:0]  o_served
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_start;
  logic             w_capture;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;
  logic [N_REQ-1:0] w_arb_gnt;
  logic [N_REQ-1:0] r_winner;
  logic [2:0]       w_win_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt)
  );

  assign w_win_idx  = onehot_to_idx(8'(r_winner));
  assign w_ptr_next = PTR_W'((int'(w_win_idx) + 1) % N_REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|i_req && !i_empty) begin
          w_start      = 1'b1;
          w_state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        w_capture    = 1'b1;
        w_state_next = ST_RELEASE;
      end
      ST_RELEASE: w_state_next = ST_SETTLE;
      ST_SETTLE:  w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Every output is a flop so the FIFO read line cannot glitch; the ASSERT
  // edge captures the head word before the RELEASE falling edge retires it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_line <= 1'b0;
      o_gnt     <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_served  <= '0;
      r_ptr     <= '0;
      r_winner  <= '0;
    end else begin
      o_rd_line <= w_start;
      o_valid   <= w_capture;
      o_gnt     <= w_capture ? r_winner : '0;
      if (w_start) r_winner <= w_arb_gnt;
      if (w_capture) begin
        o_data <= i_rd_data;
        r_ptr  <= w_ptr_next;
        if (o_served != '1) o_served <= o_served + CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_rd_scheduler
// Brief   : Scoreboard bench for fifo_rd_scheduler (4 requesters, 4-bit count).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_rd_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_req;
  logic        i_empty;
  logic [63:0] i_rd_data;
  logic        o_rd_line;
  logic [3:0]  o_gnt;
  logic        o_valid;
  logic [63:0] o_data;
  logic [3:0]  o_served;

  typedef struct {
    logic [3:0]  gnt;
    logic [63:0] data;
    int          cyc;
    logic [3:0]  served;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [63:0] mem [64];
  logic [5:0]  head;
  logic [5:0]  exp_head;
  logic [3:0]  served_m;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        prev_rd = 1'b0;

  fifo_rd_scheduler #(
    .N_REQ      (4),
    .DATA_WIDTH (64),
    .CNT_WIDTH  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_empty   (i_empty),
    .i_rd_data (i_rd_data),
    .o_rd_line (o_rd_line),
    .o_gnt     (o_gnt),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_served  (o_served)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: the falling edge of the read line retires the head word.
  assign i_rd_data = mem[head];
  always @(negedge o_rd_line) head = head + 6'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] g, input int c);
    if (served_m != 4'hF) served_m = served_m + 4'd1;
    sb.push_back('{g, mem[exp_head], c, served_m});
    exp_head = exp_head + 6'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
    head     = '0;
    exp_head = '0;
    served_m = '0;
  endtask

  always @(negedge clk) begin
    if (o_rd_line) check("rd_line_one_cycle", 64'(prev_rd), 64'd0);
    if (o_valid) begin
      check("valid_follows_rd_line", 64'(prev_rd), 64'd1);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got gnt %b at cycle %0d, expected no grant", o_gnt, cyc);
      end else begin
        e = sb.pop_front();
        check("gnt", 64'(o_gnt), 64'(e.gnt));
        check("data", o_data, e.data);
        check("served", 64'(o_served), 64'(e.served));
        check("valid_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_rd = o_rd_line;
  end

  initial begin
    int k;
    mem[0] = 64'hA5;
    for (int i = 1; i < 64; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    head = '0; exp_head = '0; served_m = '0;
    rst_n = 1'b0; i_req = '0; i_empty = 1'b1;

    // Reset state
    tick();
    check("rst_rd_line", 64'(o_rd_line), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_gnt", 64'(o_gnt), 64'd0);
    check("rst_data", o_data, 64'd0);
    check("rst_served", 64'(o_served), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single requester, request dropped once latched
    k = cyc;
    i_empty = 1'b0;
    i_req   = 4'b0001;
    push(4'b0001, k + 2);
    tick();
    check("single_rd_line_high", 64'(o_rd_line), 64'd1);
    i_req = 4'b0000;
    tick();
    check("single_rd_line_low", 64'(o_rd_line), 64'd0);
    drain(20);

    // Round robin with every requester active
    do_reset();
    k = cyc;
    i_req = 4'b1111;
    push(4'b0001, k + 2);
    push(4'b0010, k + 6);
    push(4'b0100, k + 10);
    push(4'b1000, k + 14);
    push(4'b0001, k + 18);
    repeat (17) tick();
    i_req = 4'b0000;
    drain(20);

    // Empty FIFO blocks all service
    i_empty = 1'b1;
    i_req   = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("empty_rd_line", 64'(o_rd_line), 64'd0);
      check("empty_valid", 64'(o_valid), 64'd0);
    end
    i_req = 4'b0000;

    // Empty rises during ASSERT: one word completes, then IDLE holds
    tick();
    k = cyc;
    i_empty = 1'b0;
    i_req   = 4'b0100;
    push(4'b0100, k + 2);
    tick();
    i_empty = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("empty_mid_rd_line", 64'(o_rd_line), 64'd0);
    end
    drain(5);
    i_req = 4'b0000;

    // Reset during ASSERT, then saturation over 20 words
    tick();
    i_empty = 1'b0;
    i_req   = 4'b0010;
    tick();
    check("pre_reset_rd_line", 64'(o_rd_line), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rd_line", 64'(o_rd_line), 64'd0);
    check("async_rst_valid", 64'(o_valid), 64'd0);
    check("async_rst_served", 64'(o_served), 64'd0);
    i_req = 4'b1111;
    tick();
    tick();
    rst_n    = 1'b1;
    head     = '0;
    exp_head = '0;
    served_m = '0;
    k = cyc;
    for (int i = 0; i < 20; i++) push(4'b0001 << (i % 4), k + 2 + 4 * i);
    repeat (77) tick();
    i_req = 4'b0000;
    drain(20);
    check("final_served_saturated", 64'(o_served), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
